// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int IMEM_BYTES_DEFAULT = 32;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_LOAD,
        LDR_CHECK,
        LDR_RUN,
        LDR_ERROR
    } ldr_state_e;

endpackage

// File: rtl/imem_checksum.sv
// 8-bit modular byte accumulator with a zero-result flag; used only when
// the loader is built with IMEM_LOADER_CHECKSUM_EN.
module imem_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       strobe,
    input  logic [7:0] data,
    output logic       zero
);

    logic [7:0] acc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (strobe) begin
            acc <= acc + data;
        end
    end

    assign zero = (acc == 8'h00);

endmodule

// File: rtl/imem_loader.sv
// Streams a boot image into instruction memory and holds the processor until
// the image is committed. Define IMEM_LOADER_CHECKSUM_EN to require a trailing
// checksum byte that must bring the modulo-256 byte sum to zero.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int MEM_BYTES = IMEM_BYTES_DEFAULT,
    localparam int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              run,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

    ldr_state_e        state, next_state;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic              restart;
    logic              in_ready_d;

    assign accept  = in_valid && in_ready;
    assign restart = start && (state == LDR_IDLE || state == LDR_RUN || state == LDR_ERROR);
    assign busy    = (state == LDR_LOAD) || (state == LDR_CHECK);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic check_done;
    logic sum_zero;

    imem_checksum u_checksum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (restart),
        .strobe (accept),
        .data   (in_data),
        .zero   (sum_zero)
    );
`endif

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        in_ready_d = 1'b0;
        unique case (state)
            LDR_IDLE, LDR_RUN, LDR_ERROR: begin
                if (start) next_state = LDR_LOAD;
            end
            LDR_LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept && cnt == LAST_ADDR) next_state = LDR_CHECK;
`else
                if (accept && cnt == LAST_ADDR) next_state = LDR_RUN;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LDR_CHECK: begin
                // The sum includes the check byte only one edge after it is accepted.
                if (check_done) next_state = sum_zero ? LDR_RUN : LDR_ERROR;
            end
`endif
            default: next_state = LDR_IDLE;
        endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready_d = (next_state == LDR_LOAD) ||
                     (next_state == LDR_CHECK &&
                      !(check_done || (state == LDR_CHECK && accept)));
`else
        in_ready_d = (next_state == LDR_LOAD);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LDR_IDLE;
            cnt      <= '0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            run      <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= in_ready_d;
            wr_en    <= accept && (state == LDR_LOAD);
            // Holding run low on the entry edge delays release until the last byte commits.
            run      <= (state == LDR_RUN) && (next_state == LDR_RUN);
            if (restart) begin
                cnt <= '0;
            end else if (accept && state == LDR_LOAD) begin
                wr_addr <= cnt;
                wr_data <= in_data;
                cnt     <= cnt + 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= (next_state == LDR_ERROR);
            if (restart) begin
                check_done <= 1'b0;
            end else if (accept && state == LDR_CHECK) begin
                check_done <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
